// File: rtl/whackamole_uart_pkg.sv
// Shared constants, state types and score-to-digit helpers for the whack-a-mole UART link.
package whackamole_uart_pkg;

    // ASCII command and reply bytes
    localparam logic [7:0] CMD_START  = 8'h53; // 'S'
    localparam logic [7:0] CMD_HIT    = 8'h48; // 'H'
    localparam logic [7:0] CMD_QUERY  = 8'h3F; // '?'
    localparam logic [7:0] RSP_OK     = 8'h4B; // 'K'
    localparam logic [7:0] RSP_YES    = 8'h59; // 'Y'
    localparam logic [7:0] RSP_NO     = 8'h4E; // 'N'
    localparam logic [7:0] RSP_ERR    = 8'h45; // 'E'
    localparam logic [7:0] ASCII_ZERO = 8'h30; // '0'
    localparam logic [7:0] DIGIT_MAX  = 8'h34; // '4', highest mole index

    typedef enum logic {
        PIdle,
        PGotH
    } parse_state_e;

    typedef enum logic [1:0] {
        TIdle,
        TWaitBusy,
        TWaitDone
    } tx_state_e;

    // Tens digit of a 0..63 score by compare chain, avoiding a divider
    function automatic logic [3:0] score_tens(input logic [5:0] s);
        logic [3:0] t;
        if (s >= 6'd60)      t = 4'd6;
        else if (s >= 6'd50) t = 4'd5;
        else if (s >= 6'd40) t = 4'd4;
        else if (s >= 6'd30) t = 4'd3;
        else if (s >= 6'd20) t = 4'd2;
        else if (s >= 6'd10) t = 4'd1;
        else                 t = 4'd0;
        return t;
    endfunction

    // Ones digit given the score and its already-computed tens digit
    function automatic logic [3:0] score_ones(input logic [5:0] s, input logic [3:0] tens);
        logic [5:0] tens_x10;
        tens_x10 = {2'b00, tens} * 6'd10;
        return 4'(s - tens_x10);
    endfunction

    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        return ASCII_ZERO + {4'h0, d};
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// Reply byte FIFO: up to two bytes written per cycle, one byte read per cycle.
// An empty FIFO forwards write port 0 to the read port so a byte can be written and
// popped in the same cycle.
module resp_fifo #(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      wr_cnt_i,
    input  logic [7:0]      wr_data0_i,
    input  logic [7:0]      wr_data1_i,
    input  logic            rd_en_i,
    output logic [7:0]      rd_data_o,
    output logic [CntW-1:0] free_o,
    output logic            empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

    logic [7:0]      mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_nxt;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    assign wr_ptr_nxt = wr_ptr_q + PtrW'(1);
    assign empty_o    = (count_q == '0);
    assign free_o     = DepthC - count_q;
    assign rd_data_o  = empty_o ? wr_data0_i : mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; pointers wrap because DEPTH is a power of 2
    always_comb begin
        wr_ptr_d = wr_ptr_q + PtrW'(wr_cnt_i);
        rd_ptr_d = rd_ptr_q + PtrW'(rd_en_i);
        count_d  = count_q + CntW'(wr_cnt_i) - CntW'(rd_en_i);
    end

    // Pointer and count registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless until written, so no reset
    always_ff @(posedge clock) begin
        if (wr_cnt_i != 2'd0) begin
            mem_q[wr_ptr_q] <= wr_data0_i;
        end
        if (wr_cnt_i == 2'd2) begin
            mem_q[wr_ptr_nxt] <= wr_data1_i;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Whack-a-mole PC command decoder: parses 'S', 'H<d>' and '?' from uart_rx, emits game
// pulses, queues ASCII replies and drains them to uart_tx with a busy handshake.
module uart_cmd_parser
    import whackamole_uart_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned BUSY_WAIT      = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    input  logic [4:0] mole_position,
    input  logic       game_active,
    input  logic [5:0] score,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       start_pulse,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic       cmd_error,
    output logic       resp_drop
);

    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
    localparam int unsigned BusyW = $clog2(BUSY_WAIT) + 1;
    localparam logic [BusyW-1:0] BusyLast = BusyW'(BUSY_WAIT - 1);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    // Parser state
    parse_state_e      p_state_q, p_state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              start_q, start_d;
    logic              hit_q, hit_d;
    logic              miss_q, miss_d;
    logic              err_q, err_d;
    // Pending reply from the decision cycle, written to the FIFO one cycle later
    logic [1:0]        req_cnt_q, req_cnt_d;
    logic [7:0]        req_byte0_q, req_byte0_d;
    logic [7:0]        req_byte1_q, req_byte1_d;

    // FIFO interface
    logic [1:0]        wr_cnt;
    logic              fits;
    logic              fifo_empty;
    logic [CntW-1:0]   fifo_free;
    logic [7:0]        fifo_rd_data;
    logic              can_pop;

    // TX state
    tx_state_e         tx_state_q, tx_state_d;
    logic [BusyW-1:0]  busy_cnt_q, busy_cnt_d;
    logic              pop;
    logic              tx_start_q;
    logic [7:0]        tx_data_q;

    logic [3:0]        tens, ones;

    assign tens = score_tens(score);
    assign ones = score_ones(score, tens);

    // Parser next-state: decide on rx_ready, or on the 'H' digit timeout
    always_comb begin
        p_state_d   = p_state_q;
        timer_d     = timer_q;
        start_d     = 1'b0;
        hit_d       = 1'b0;
        miss_d      = 1'b0;
        err_d       = 1'b0;
        req_cnt_d   = 2'd0;
        req_byte0_d = 8'h00;
        req_byte1_d = 8'h00;
        unique case (p_state_q)
            PIdle: begin
                if (rx_ready) begin
                    case (rx_data)
                        CMD_START: begin
                            start_d     = 1'b1;
                            req_cnt_d   = 2'd1;
                            req_byte0_d = RSP_OK;
                        end
                        CMD_QUERY: begin
                            req_cnt_d   = 2'd2;
                            req_byte0_d = digit_ascii(tens);
                            req_byte1_d = digit_ascii(ones);
                        end
                        CMD_HIT: begin
                            p_state_d = PGotH;
                            timer_d   = '0;
                        end
                        default: begin
                            err_d       = 1'b1;
                            req_cnt_d   = 2'd1;
                            req_byte0_d = RSP_ERR;
                        end
                    endcase
                end
            end
            PGotH: begin
                if (rx_ready) begin
                    // A byte arriving on the timeout cycle takes priority
                    p_state_d = PIdle;
                    req_cnt_d = 2'd1;
                    if (rx_data >= ASCII_ZERO && rx_data <= DIGIT_MAX) begin
                        if (game_active && mole_position[rx_data[2:0]]) begin
                            hit_d       = 1'b1;
                            req_byte0_d = RSP_YES;
                        end else begin
                            miss_d      = 1'b1;
                            req_byte0_d = RSP_NO;
                        end
                    end else begin
                        err_d       = 1'b1;
                        req_byte0_d = RSP_ERR;
                    end
                end else if (timer_q == TimerLast) begin
                    p_state_d   = PIdle;
                    err_d       = 1'b1;
                    req_cnt_d   = 2'd1;
                    req_byte0_d = RSP_ERR;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            default: p_state_d = PIdle;
        endcase
    end

    // Parser registers and registered action pulses
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            p_state_q   <= PIdle;
            timer_q     <= '0;
            start_q     <= 1'b0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            err_q       <= 1'b0;
            req_cnt_q   <= 2'd0;
            req_byte0_q <= 8'h00;
            req_byte1_q <= 8'h00;
        end else begin
            p_state_q   <= p_state_d;
            timer_q     <= timer_d;
            start_q     <= start_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            err_q       <= err_d;
            req_cnt_q   <= req_cnt_d;
            req_byte0_q <= req_byte0_d;
            req_byte1_q <= req_byte1_d;
        end
    end

    // All-or-nothing reply write against the room available before this cycle's pop
    assign fits      = (CntW'(req_cnt_q) <= fifo_free);
    assign wr_cnt    = fits ? req_cnt_q : 2'd0;
    assign resp_drop = (req_cnt_q != 2'd0) && !fits;

    assign start_pulse = start_q;
    assign hit_pulse   = hit_q;
    assign miss_pulse  = miss_q;
    assign cmd_error   = err_q;

    resp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_resp_fifo (
        .clock      (clock),
        .reset      (reset),
        .wr_cnt_i   (wr_cnt),
        .wr_data0_i (req_byte0_q),
        .wr_data1_i (req_byte1_q),
        .rd_en_i    (pop),
        .rd_data_o  (fifo_rd_data),
        .free_o     (fifo_free),
        .empty_o    (fifo_empty)
    );

    // A byte being written this cycle can be popped straight through
    assign can_pop = !fifo_empty || (wr_cnt != 2'd0);

    // TX handshake next-state: pop and strobe, wait for busy to rise, then to fall
    always_comb begin
        tx_state_d = tx_state_q;
        busy_cnt_d = busy_cnt_q;
        pop        = 1'b0;
        unique case (tx_state_q)
            TIdle: begin
                if (!tx_busy && can_pop) begin
                    pop        = 1'b1;
                    busy_cnt_d = '0;
                    tx_state_d = TWaitBusy;
                end
            end
            TWaitBusy: begin
                if (tx_busy) begin
                    tx_state_d = TWaitDone;
                end else if (busy_cnt_q == BusyLast) begin
                    // uart_tx never acknowledged; give up on this byte
                    tx_state_d = TIdle;
                end else begin
                    busy_cnt_d = busy_cnt_q + BusyW'(1);
                end
            end
            TWaitDone: begin
                if (!tx_busy) begin
                    tx_state_d = TIdle;
                end
            end
            default: tx_state_d = TIdle;
        endcase
    end

    // TX registers; tx_data holds the popped byte until the next pop
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TIdle;
            busy_cnt_q <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            tx_state_q <= tx_state_d;
            busy_cnt_q <= busy_cnt_d;
            tx_start_q <= pop;
            if (pop) begin
                tx_data_q <= fifo_rd_data;
            end
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: a string-level reference model predicts pulses
// and reply bytes, a monitor checks them as the DUT presents them.
module tb_uart_cmd_parser;

    localparam int unsigned TIMEOUT = 40;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned BWAIT   = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready = 1'b0;
    logic [4:0] mole_position = 5'b0;
    logic       game_active = 1'b0;
    logic [5:0] score = 6'd0;
    logic       tx_busy;
    logic       model_busy = 1'b0;
    logic       hold_busy = 1'b0;
    logic [7:0] tx_data;
    logic       tx_start, start_pulse, hit_pulse, miss_pulse, cmd_error, resp_drop;

    assign tx_busy = model_busy | hold_busy;

    uart_cmd_parser #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .FIFO_DEPTH     (DEPTH),
        .BUSY_WAIT      (BWAIT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_ready      (rx_ready),
        .mole_position (mole_position),
        .game_active   (game_active),
        .score         (score),
        .tx_busy       (tx_busy),
        .tx_data       (tx_data),
        .tx_start      (tx_start),
        .start_pulse   (start_pulse),
        .hit_pulse     (hit_pulse),
        .miss_pulse    (miss_pulse),
        .cmd_error     (cmd_error),
        .resp_drop     (resp_drop)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Expected pulse event: cycle seen and {drop, err, miss, hit, start}
    typedef struct {
        int         cyc;
        logic [4:0] vec;
    } ev_t;

    ev_t        exp_ev[$];
    logic [7:0] exp_tx[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         tb_got_h = 0;
    int         model_free = DEPTH;
    int         last_n = 0;
    int         last_tx_cyc = -1;
    int         busy_len = 3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour: pulses and reply text for one received byte
    function automatic void ref_model(input bit got_h, input logic [7:0] b, input int sc,
                                      input logic [4:0] mole, input bit ga,
                                      output logic [3:0] p, output string r, output bit nh);
        int d;
        p  = 4'b0000;
        r  = "";
        nh = 1'b0;
        if (!got_h) begin
            if (b == "S") begin
                p = 4'b0001;
                r = "K";
            end else if (b == "?") begin
                r = $sformatf("%0d%0d", sc / 10, sc % 10);
            end else if (b == "H") begin
                nh = 1'b1;
            end else begin
                p = 4'b1000;
                r = "E";
            end
        end else if (b >= "0" && b <= "4") begin
            d = int'(b) - 48;
            if (ga && mole[d]) begin
                p = 4'b0010;
                r = "Y";
            end else begin
                p = 4'b0100;
                r = "N";
            end
        end else begin
            p = 4'b1000;
            r = "E";
        end
    endfunction

    task automatic send_byte(input logic [7:0] b, output int n);
        @(posedge clock);
        #1;
        rx_data  = b;
        rx_ready = 1'b1;
        n        = cyc;
        @(posedge clock);
        #1;
        rx_ready = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    // Send a byte, predict its outcome and push the expectations, then idle for gap cycles
    task automatic issue(input logic [7:0] b, input int gap);
        logic [3:0] p;
        string      r;
        bit         nh;
        bit         drop;
        int         n;
        if (!hold_busy) model_free = DEPTH;
        ref_model(tb_got_h, b, int'(score), mole_position, game_active, p, r, nh);
        send_byte(b, n);
        last_n   = n;
        tb_got_h = nh;
        drop     = 1'b0;
        if (r.len() > 0) begin
            if (model_free >= r.len()) begin
                for (int i = 0; i < r.len(); i++) exp_tx.push_back(r[i]);
                model_free -= r.len();
            end else begin
                drop = 1'b1;
            end
        end
        if (p != 4'b0 || drop) exp_ev.push_back(ev_t'{cyc: n + 1, vec: {drop, p}});
        repeat (gap) @(posedge clock);
    endtask

    // 'H' followed by silence: error expected TIMEOUT cycles after the parser arms
    task automatic issue_h_timeout();
        issue("H", 0);
        exp_ev.push_back(ev_t'{cyc: last_n + TIMEOUT + 1, vec: 5'b01000});
        exp_tx.push_back("E");
        tb_got_h = 1'b0;
        repeat (TIMEOUT + 30) @(posedge clock);
    endtask

    // Monitor: compare every pulse and every tx_start against the scoreboard
    always @(negedge clock) begin
        logic [4:0] vec;
        ev_t        e;
        if (reset) begin
            vec = {resp_drop, cmd_error, miss_pulse, hit_pulse, start_pulse};
            if (vec != 5'b0) begin
                if (exp_ev.size() == 0) begin
                    check("unexpected_pulse", {27'b0, vec}, 32'h0);
                end else begin
                    e = exp_ev.pop_front();
                    check("pulse_cycle", cyc, e.cyc);
                    check("pulse_kind", {27'b0, vec}, {27'b0, e.vec});
                end
            end
            if (tx_start) begin
                last_tx_cyc = cyc;
                check("tx_start_while_busy", {31'b0, tx_busy}, 32'h0);
                if (exp_tx.size() == 0) check("unexpected_tx_byte", {24'b0, tx_data}, 32'h0);
                else check("tx_byte", {24'b0, tx_data}, {24'b0, exp_tx.pop_front()});
            end
        end
    end

    // uart_tx stand-in: busy rises the cycle after tx_start and lasts busy_len cycles
    initial begin
        logic [7:0] latched;
        forever begin
            @(negedge clock);
            if (tx_start && reset) begin
                latched = tx_data;
                @(posedge clock);
                #1 model_busy = 1'b1;
                repeat (busy_len) @(posedge clock);
                #1;
                check("tx_data_held", {24'b0, tx_data}, {24'b0, latched});
                model_busy = 1'b0;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_data"}, {24'b0, tx_data}, 32'h0);
        check({tag, "_tx_start"}, {31'b0, tx_start}, 32'h0);
        check({tag, "_pulses"},
              {27'b0, start_pulse, hit_pulse, miss_pulse, cmd_error, resp_drop}, 32'h0);
    endtask

    initial begin
        logic [7:0] b;
        int         kind;
        int         k;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_all_zero("reset");
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (3) @(posedge clock);

        // Start command and its reply latency
        last_tx_cyc = -1;
        issue("S", 30);
        check("s_tx_latency", last_tx_cyc, last_n + 2);

        // Hit and miss against a live mole at index 2
        game_active   = 1'b1;
        mole_position = 5'b00100;
        issue("H", 3);
        issue("2", 30);
        issue("H", 3);
        issue("3", 30);

        // Score queries
        score = 6'd42;
        issue("?", 40);
        score = 6'd7;
        issue("?", 40);

        // Timeout and malformed commands
        issue_h_timeout();
        issue("H", 2);
        issue("9", 30);
        issue("x", 30);

        // FIFO fills while uart_tx stays busy; third reply must be dropped
        hold_busy  = 1'b1;
        model_free = DEPTH;
        score      = 6'd42;
        issue("?", 5);
        issue("?", 5);
        issue("?", 5);
        hold_busy = 1'b0;
        repeat (80) @(posedge clock);

        // Reset with two bytes queued and the parser holding an 'H'
        hold_busy  = 1'b1;
        model_free = DEPTH;
        issue("?", 3);
        issue("H", 3);
        @(posedge clock);
        #1 reset = 1'b0;
        exp_tx.delete();
        exp_ev.delete();
        tb_got_h   = 1'b0;
        model_free = DEPTH;
        @(negedge clock);
        check_all_zero("midreset");
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        hold_busy = 1'b0;
        repeat (20) @(posedge clock);
        issue("1", 30);

        // Randomised command mix
        for (int it = 0; it < 40; it++) begin
            score         = 6'($urandom_range(0, 63));
            k             = $urandom_range(0, 5);
            mole_position = (k == 0) ? 5'b0 : 5'(1 << (k - 1));
            game_active   = ($urandom_range(0, 3) != 0);
            busy_len      = $urandom_range(1, 5);
            kind          = $urandom_range(0, 5);
            case (kind)
                0: issue("S", 30);
                1: issue("?", 30);
                2: begin
                    issue("H", $urandom_range(0, 10));
                    issue(8'(48 + $urandom_range(0, 4)), 30);
                end
                3: begin
                    issue("H", $urandom_range(0, 10));
                    do b = 8'($urandom); while (b >= "0" && b <= "4");
                    issue(b, 30);
                end
                4: issue_h_timeout();
                default: begin
                    do b = 8'($urandom); while (b == "S" || b == "?" || b == "H");
                    issue(b, 30);
                end
            endcase
        end

        // Drain with a bound, then account for anything never delivered
        for (int w = 0; w < 300 && (exp_tx.size() != 0 || exp_ev.size() != 0); w++) begin
            @(posedge clock);
        end
        check("leftover_tx_bytes", exp_tx.size(), 0);
        check("leftover_pulses", exp_ev.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
